// File: rtl/junction_phase_arbiter_if.sv
// Signal-head bus between the junction arbiter and its surroundings:
// sensor/emergency inputs toward the arbiter, light codes and grant status back.
interface junction_phase_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2
);
  logic [N-1:0]     req;
  logic             emg;
  logic [IDX_W-1:0] emg_dir;
  logic [2*N-1:0]   lights;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic [1:0]       phase;

  modport master (
    output req, emg, emg_dir,
    input  lights, grant_idx, grant_vld, phase
  );

  modport slave (
    input  req, emg, emg_dir,
    output lights, grant_idx, grant_vld, phase
  );
endinterface

// File: rtl/junction_phase_arbiter.sv
// Junction right-of-way arbiter: one approach GREEN at a time, round-robin over
// sensor requests with min/max green, fixed yellow, all-red clearance and
// emergency preemption. Moore outputs decoded from registered state/grant.
module junction_phase_arbiter #(
  parameter int N          = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2
) (
  input  logic                     clock,
  input  logic                     clear_n,
  junction_phase_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_t;

  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYC - 1);

  phase_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic [IDX_W-1:0] grant_q, grant_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;

  logic             emg_ok;
  logic             emg_own;
  logic             emg_other;
  logic [N-1:0]     grant_oh;
  logic             other;
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;

  // Emergency qualification and competing-demand detection
  always_comb begin
    emg_ok    = bus.emg && (32'(bus.emg_dir) < N);
    emg_own   = emg_ok && (bus.emg_dir == grant_q);
    emg_other = emg_ok && (bus.emg_dir != grant_q);
    grant_oh  = N'(1) << grant_q;
    other     = (|(bus.req & ~grant_oh)) | emg_other;
  end

  // Round-robin scan starting just after the last granted approach
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned cand;
      cand = (32'(ptr_q) + k) % N;
      if (!rr_found && bus.req[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state, next-grant and pointer update
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    ptr_nxt   = ptr_q;
    case (state)
      ALLRED: begin
        if (timer >= AR_LAST) begin
          if (emg_ok) begin
            state_nxt = GREEN;
            grant_nxt = bus.emg_dir;
            ptr_nxt   = bus.emg_dir;
          end else if (rr_found) begin
            state_nxt = GREEN;
            grant_nxt = rr_idx;
            ptr_nxt   = rr_idx;
          end
        end
      end
      GREEN: begin
        // An emergency for the current approach suppresses the normal exit
        // rule entirely, so GREEN is held past MAX_GREEN while it lasts.
        if (emg_other) begin
          state_nxt = YELLOW;
        end else if (!emg_own && (timer >= MIN_LAST) && other &&
                     (!bus.req[grant_q] || (timer >= MAX_LAST))) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (timer >= Y_LAST) state_nxt = ALLRED;
      end
      default: state_nxt = ALLRED;
    endcase
  end

  // State, grant, pointer and saturating phase timer registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= ALLRED;
      timer   <= '0;
      grant_q <= '0;
      ptr_q   <= IDX_W'(N - 1);
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      ptr_q   <= ptr_nxt;
      if (state_nxt != state) timer <= '0;
      else if (timer != '1)   timer <= timer + 1'b1;
    end
  end

  // Light codes and grant status decoded from registered state
  always_comb begin
    bus.lights = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q == IDX_W'(i)) begin
        if (state == GREEN)       bus.lights[2*i +: 2] = 2'd2;
        else if (state == YELLOW) bus.lights[2*i +: 2] = 2'd1;
      end
    end
    bus.grant_idx = grant_q;
    bus.grant_vld = (state != ALLRED);
    bus.phase     = state;
  end

endmodule

// File: tb/tb_junction_phase_arbiter.sv
// Bench for junction_phase_arbiter: phase-level behavioural model checked every
// cycle, a green-interval log built from the outputs, and directed scenarios.
module tb_junction_phase_arbiter;

  localparam int N          = 4;
  localparam int MIN_GREEN  = 4;
  localparam int MAX_GREEN  = 10;
  localparam int YELLOW_CYC = 3;
  localparam int ALLRED_CYC = 2;

  localparam int P_AR = 0;
  localparam int P_G  = 1;
  localparam int P_Y  = 2;

  logic clock = 1'b0;
  logic clear_n;

  always #5 clock = ~clock;

  junction_phase_arbiter_if #(.N(4), .IDX_W(2)) bus ();

  junction_phase_arbiter #(
    .N(4), .IDX_W(2), .CNT_W(8), .MIN_GREEN(4), .MAX_GREEN(10),
    .YELLOW_CYC(3), .ALLRED_CYC(2)
  ) dut (
    .clock(clock),
    .clear_n(clear_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // model state: phase, cycles spent in it, owner, last-served approach
  int m_phase = P_AR;
  int m_cnt   = 0;
  int m_grant = 0;
  int m_ptr   = N - 1;

  // green intervals observed on the outputs: owner and length in cycles
  int glog_idx[$];
  int glog_len[$];
  int run     = 0;
  int prev_g  = 0;
  bit in_grn  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nph;
    int  ng;
    int  r;
    bit  eok;
    bit  oth;
    logic [N-1:0] rq;
    rq  = bus.req;
    eok = bus.emg && (int'(bus.emg_dir) < N);
    oth = 1'b0;
    for (int j = 0; j < N; j++) if (j != m_grant && rq[j]) oth = 1'b1;
    if (eok && int'(bus.emg_dir) != m_grant) oth = 1'b1;
    nph = m_phase;
    ng  = m_grant;
    if (m_phase == P_AR) begin
      if (m_cnt >= ALLRED_CYC - 1) begin
        if (eok) begin
          nph = P_G; ng = int'(bus.emg_dir);
        end else begin
          for (int k = 1; k <= N; k++) begin
            r = (m_ptr + k) % N;
            if (nph == P_AR && rq[r]) begin nph = P_G; ng = r; end
          end
        end
        if (nph == P_G) m_ptr = ng;
      end
    end else if (m_phase == P_G) begin
      if (eok && int'(bus.emg_dir) != m_grant) nph = P_Y;
      else if (!(eok && int'(bus.emg_dir) == m_grant) && m_cnt >= MIN_GREEN - 1 && oth &&
               (!rq[m_grant] || m_cnt >= MAX_GREEN - 1)) nph = P_Y;
    end else begin
      if (m_cnt >= YELLOW_CYC - 1) nph = P_AR;
    end
    if (nph != m_phase) m_cnt = 0;
    else if (m_cnt < 255) m_cnt++;
    m_phase = nph;
    m_grant = ng;
  endtask

  // Advance the model on each edge, then compare outputs and log green intervals
  always @(posedge clock) begin
    logic [2*N-1:0] el;
    if (!clear_n) begin
      m_phase = P_AR; m_cnt = 0; m_grant = 0; m_ptr = N - 1;
    end else begin
      model_step();
    end
    #2;
    el = '0;
    if (m_phase == P_G) el[2*m_grant +: 2] = 2'd2;
    if (m_phase == P_Y) el[2*m_grant +: 2] = 2'd1;
    chk("lights",    int'(bus.lights),    int'(el));
    chk("phase",     int'(bus.phase),     m_phase);
    chk("grant_vld", int'(bus.grant_vld), int'(m_phase != P_AR));
    chk("grant_idx", int'(bus.grant_idx), m_grant);
    if (!clear_n) begin
      in_grn = 1'b0; run = 0;
    end else if (bus.phase == 2'd1) begin
      if (in_grn && int'(bus.grant_idx) == prev_g) run++;
      else begin run = 1; prev_g = int'(bus.grant_idx); end
      in_grn = 1'b1;
    end else begin
      if (in_grn) begin glog_idx.push_back(prev_g); glog_len.push_back(run); end
      in_grn = 1'b0;
    end
  end

  task automatic wait_phase(input int ph, input int g, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (int'(bus.phase) == ph && (g < 0 || int'(bus.grant_idx) == g)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_log(input int n, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (glog_len.size() >= n) break;
      @(negedge clock);
    end
    chk(name, glog_len.size(), n);
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    clear_n     = 1'b0;
    bus.req     = '0;
    bus.emg     = 1'b0;
    bus.emg_dir = '0;
    repeat (3) @(negedge clock);

    // 1: reset state, then two all-red cycles before approach 0 goes green
    chk("rst_lights", int'(bus.lights), 0);
    chk("rst_phase",  int'(bus.phase), 0);
    chk("rst_vld",    int'(bus.grant_vld), 0);
    chk("rst_grant",  int'(bus.grant_idx), 0);
    bus.req = 4'b0001;
    clear_n = 1'b1;
    @(negedge clock);
    chk("t1_allred", int'(bus.phase), 0);
    @(negedge clock);
    chk("t1_green_lights", int'(bus.lights), 8'h02);
    chk("t1_green_grant",  int'(bus.grant_idx), 0);
    chk("t1_model_phase",  m_phase, P_G);
    repeat (20) @(negedge clock);
    chk("t1_rest", int'(bus.lights), 8'h02);

    // 2: two competing approaches alternate at MAX_GREEN
    glog_idx.delete(); glog_len.delete();
    bus.req = 4'b0011;
    wait_log(3, 100, "t2_log");
    if (glog_len.size() >= 3) begin
      chk("t2_g1_idx", glog_idx[1], 1);
      chk("t2_g1_len", glog_len[1], 10);
      chk("t2_g0_idx", glog_idx[2], 0);
      chk("t2_g0_len", glog_len[2], 10);
    end

    // 3: own request drops early -> green ends at MIN_GREEN
    bus.req = 4'b0001;
    wait_phase(P_Y, -1, 40, "t3_wait_y");
    wait_phase(P_G, 0, 40, "t3_wait_g0");
    glog_idx.delete(); glog_len.delete();
    @(negedge clock);
    bus.req = 4'b0010;
    wait_log(1, 40, "t3_log");
    if (glog_len.size() >= 1) begin
      chk("t3_idx", glog_idx[0], 0);
      chk("t3_len", glog_len[0], 4);
    end

    // 6: asynchronous reset in the middle of a yellow
    wait_phase(P_G, 1, 40, "t6_wait_g1");
    bus.req = 4'b0001;
    wait_phase(P_Y, 1, 40, "t6_wait_y");
    #2 clear_n = 1'b0;
    #1;
    chk("t6_async_lights", int'(bus.lights), 0);
    chk("t6_async_phase",  int'(bus.phase), 0);
    chk("t6_async_vld",    int'(bus.grant_vld), 0);
    chk("t6_async_grant",  int'(bus.grant_idx), 0);
    repeat (2) @(negedge clock);
    bus.req = 4'b1111;
    glog_idx.delete(); glog_len.delete();
    clear_n = 1'b1;
    @(negedge clock);
    chk("t6_allred", int'(bus.phase), 0);
    @(negedge clock);
    chk("t6_green_lights", int'(bus.lights), 8'h02);

    // 4: all approaches requesting -> strict rotation, 10-cycle greens
    wait_log(5, 200, "t4_log");
    if (glog_len.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("t4_idx%0d", k), glog_idx[k], exp_order[k]);
        chk($sformatf("t4_len%0d", k), glog_len[k], 10);
      end
    end

    // 5: emergency preemption toward approach 3
    wait_phase(P_G, 1, 40, "t5_wait_g1");
    @(negedge clock);
    bus.emg     = 1'b1;
    bus.emg_dir = 2'd3;
    @(negedge clock);
    chk("t5_yellow", int'(bus.phase), P_Y);
    wait_phase(P_G, -1, 20, "t5_wait_g");
    chk("t5_grant3", int'(bus.grant_idx), 3);
    repeat (30) @(negedge clock);
    chk("t5_hold_phase",  int'(bus.phase), P_G);
    chk("t5_hold_lights", int'(bus.lights), 8'h80);
    bus.emg = 1'b0;
    @(negedge clock);
    chk("t5_release", int'(bus.phase), P_Y);
    repeat (10) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
